// File: rtl/layer1_neuron_mac_pkg.sv
// Fixed-point constants and FSM state type shared by the layer-1 neuron MAC
// and the tanh LUT/interpolator stage.
package nn_fixed_pkg;

  localparam int DATA_W = 8;
  localparam int FRAC   = 4;

  localparam logic signed [7:0] Q44_MAX = 8'sd127;
  localparam logic signed [7:0] Q44_MIN = -8'sd128;
  localparam logic signed [7:0] Q44_ONE = 8'sd16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/layer1_neuron_mac_if.sv
// Operand stream (x/w pairs) and result stream (z) handshakes of the neuron MAC.
interface layer1_neuron_mac_if #(
  parameter int DATA_W = 8
);

  logic              x_valid;
  logic              x_ready;
  logic [DATA_W-1:0] x_data;
  logic [DATA_W-1:0] w_data;
  logic              z_valid;
  logic              z_ready;
  logic [DATA_W-1:0] z_value;

  modport master (
    output x_valid, x_data, w_data, z_ready,
    input  x_ready, z_valid, z_value
  );

  modport slave (
    input  x_valid, x_data, w_data, z_ready,
    output x_ready, z_valid, z_value
  );

endinterface

// File: rtl/layer1_neuron_mac_sat_shift.sv
// Rescale an accumulator by an arithmetic right shift (floor) and clamp it
// into the signed DATA_W output range.
module nn_sat_shift #(
  parameter int ACC_W  = 20,
  parameter int DATA_W = 8,
  parameter int FRAC   = 4
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] z
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> FRAC;
    z       = shifted[DATA_W-1:0];
    if (shifted > MAX_V) begin
      z = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      z = MIN_V[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/layer1_neuron_mac.sv
// Serial multiply-accumulate neuron: bias plus N_INPUTS x*w products, rescaled
// to Q4.4 and saturated, delivered over a valid/ready result handshake.
module layer1_neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = nn_fixed_pkg::DATA_W,
  parameter int FRAC     = nn_fixed_pkg::FRAC,
  parameter int ACC_W    = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  layer1_neuron_mac_if.slave       io,
  output logic                     busy
);

  import nn_fixed_pkg::*;

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t                    state, state_next;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]  sat_out;
  logic                      beat;

  assign beat     = io.x_ready && io.x_valid;
  assign prod     = signed'(io.x_data) * signed'(io.w_data);
  assign acc_next = acc + ACC_W'(prod);
  assign bias_ext = ACC_W'(bias) <<< FRAC;
  assign busy     = (state != IDLE);

  // The final beat's sum is saturated directly so z_value is ready on DONE entry.
  nn_sat_shift #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC  (FRAC)
  ) u_sat (
    .acc(acc_next),
    .z  (sat_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (beat && (cnt == LAST)) state_next = DONE;
      DONE:    if (io.z_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      io.x_ready <= 1'b0;
      io.z_valid <= 1'b0;
      io.z_value <= '0;
    end else begin
      io.x_ready <= (state_next == ACCUM);
      io.z_valid <= (state_next == DONE);
      if ((state == IDLE) && start) begin
        acc <= bias_ext;
        cnt <= '0;
      end
      if (beat) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          io.z_value <= sat_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer1_neuron_mac.sv
// Self-checking bench for layer1_neuron_mac: directed vector table, stall and
// abort sequences, and randomized passes against an arithmetic reference model.
module tb_layer1_neuron_mac;

  localparam int N = 4;

  typedef struct {
    int b;
    int x[N];
    int w[N];
    int z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [7:0] bias = '0;
  logic busy;

  int n_chk = 0;
  int n_fail = 0;

  layer1_neuron_mac_if #(.DATA_W(8)) ifc ();

  layer1_neuron_mac #(
    .N_INPUTS(N),
    .DATA_W  (8),
    .FRAC    (4),
    .ACC_W   (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bias (bias),
    .io   (ifc),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact sum at Q8.8, floor-divide by 16, clamp to Q4.4 range.
  function automatic int model(input int b, input int x[N], input int w[N]);
    int sum;
    int q;
    sum = b * 16;
    for (int i = 0; i < N; i++) sum += x[i] * w[i];
    q = sum >>> 4;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete pass; gap = idle cycles before each beat, hold = cycles z_ready stays low.
  task automatic run_pass(input string tag, input int b, input int x[N], input int w[N],
                          input int gap, input int hold, input int exp_z);
    int lat;
    int waited;
    int zval;
    ifc.z_ready = (hold == 0);
    start = 1'b1;
    bias  = 8'(b);
    lat   = 1;
    tick();
    lat++;
    start = 1'b0;
    bias  = 8'(-1);
    chk({tag, " x_ready_in_accum"}, int'(ifc.x_ready), 1);
    for (int i = 0; i < N; i++) begin
      ifc.x_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        lat++;
      end
      ifc.x_valid = 1'b1;
      ifc.x_data  = 8'(x[i]);
      ifc.w_data  = 8'(w[i]);
      tick();
      lat++;
    end
    ifc.x_valid = 1'b0;
    ifc.x_data  = '0;
    ifc.w_data  = '0;
    waited = 0;
    while (!ifc.z_valid && waited < 20) begin
      tick();
      lat++;
      waited++;
    end
    chk({tag, " z_valid_seen"}, int'(ifc.z_valid), 1);
    if (gap == 0) chk({tag, " latency"}, lat, 6);
    zval = int'($signed(ifc.z_value));
    chk({tag, " z_value"}, zval, exp_z);
    if (hold > 0) begin
      start = 1'b1;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({tag, " hold_z_valid"}, int'(ifc.z_valid), 1);
        chk({tag, " hold_z_value"}, int'($signed(ifc.z_value)), exp_z);
        chk({tag, " hold_x_ready"}, int'(ifc.x_ready), 0);
      end
      start = 1'b0;
      ifc.z_ready = 1'b1;
    end
    tick();
    chk({tag, " z_valid_drop"}, int'(ifc.z_valid), 0);
    chk({tag, " busy_drop"}, int'(busy), 0);
    ifc.z_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int rx[N];
    int rw[N];
    int rb;

    vecs[0] = '{0,    '{16, 16, 16, 16},     '{16, 16, 16, 16},     64};
    vecs[1] = '{16,   '{16, -16, 32, 0},     '{16, 16, 8, 127},     32};
    vecs[2] = '{127,  '{127, 127, 127, 127}, '{127, 127, 127, 127}, 127};
    vecs[3] = '{-128, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, -128};
    vecs[4] = '{0,    '{1, 0, 0, 0},         '{1, 0, 0, 0},         0};
    vecs[5] = '{0,    '{-1, 0, 0, 0},        '{1, 0, 0, 0},         -1};

    ifc.x_valid = 1'b0;
    ifc.x_data  = '0;
    ifc.w_data  = '0;
    ifc.z_ready = 1'b0;

    #12;
    chk("reset z_valid", int'(ifc.z_valid), 0);
    chk("reset x_ready", int'(ifc.x_ready), 0);
    chk("reset z_value", int'(ifc.z_value), 0);
    chk("reset busy", int'(busy), 0);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_pass($sformatf("vec%0d", i), vecs[i].b, vecs[i].x, vecs[i].w, 0, 0, vecs[i].z);
    end

    // Stalled operand stream and held-off result must not change the answer.
    run_pass("stall", vecs[1].b, vecs[1].x, vecs[1].w, 2, 3, vecs[1].z);

    // Abort mid-pass after a nonzero result is sitting in z_value.
    run_pass("pre_abort", vecs[0].b, vecs[0].x, vecs[0].w, 0, 0, 64);
    start = 1'b1;
    bias  = 8'sd100;
    tick();
    start = 1'b0;
    ifc.x_valid = 1'b1;
    ifc.x_data  = 8'sd100;
    ifc.w_data  = 8'sd100;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort z_valid", int'(ifc.z_valid), 0);
    chk("abort x_ready", int'(ifc.x_ready), 0);
    chk("abort z_value", int'(ifc.z_value), 0);
    chk("abort busy", int'(busy), 0);
    ifc.x_valid = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    chk("post_abort idle", int'(busy), 0);
    run_pass("post_abort", vecs[1].b, vecs[1].x, vecs[1].w, 0, 0, vecs[1].z);

    for (int r = 0; r < 25; r++) begin
      rb = int'($signed(8'($urandom)));
      for (int i = 0; i < N; i++) begin
        rx[i] = int'($signed(8'($urandom)));
        rw[i] = int'($signed(8'($urandom)));
      end
      run_pass($sformatf("rand%0d", r), rb, rx, rw, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), model(rb, rx, rw));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
